// File: rtl/nios_interrupt_jtag_debug_pkg.sv
// Shared constants for the Nios debug JTAG command path: the command
// indices carried in the virtual IR and the default register widths.
package nios_interrupt_jtag_debug_pkg;

  localparam int DEF_IR_W = 2;
  localparam int DEF_DR_W = 38;

  localparam int OCIMEM    = 0;
  localparam int TRACEMEM  = 1;
  localparam int BREAK     = 2;
  localparam int TRACECTRL = 3;

endpackage

// File: rtl/nios_interrupt_jtag_debug_pulse_sync.sv
// Brings an asynchronous update level into clk and emits a one-cycle pulse
// on each rising edge, ignoring a level already high when reset releases.
module nios_interrupt_jtag_debug_pulse_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_prev;
  logic                   r_armed;
  logic                   w_sync_out;

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  // r_fill marks when the chain holds only post-reset samples, so arming
  // is based on a genuinely observed low level, not the reset value.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values and the chain shifts exactly one stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync  <= '0;
      r_fill  <= '0;
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_prev <= w_sync_out;
      if (r_fill[SYNC_STAGES-1] && !w_sync_out) r_armed <= 1'b1;
    end
  end

  assign o_edge = r_armed & w_sync_out & ~r_prev;

endmodule

// File: rtl/nios_interrupt_jtag_debug_cmd_queue.sv
// Captures JTAG update-IR/update-DR events into a small command FIFO and
// replays them to the CPU clock domain as one-hot action/no-action pulses.
module nios_interrupt_jtag_debug_cmd_queue
  import nios_interrupt_jtag_debug_pkg::*;
#(
  parameter  int IR_W        = DEF_IR_W,
  parameter  int DR_W        = DEF_DR_W,
  parameter  int ACT_BIT     = DR_W - 1,
  parameter  int DEPTH       = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int NUM_CMD     = 2 ** IR_W,
  localparam int LVL_W       = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [IR_W-1:0]    ir_in,
  input  logic [DR_W-1:0]    sr,
  input  logic               vs_uir,
  input  logic               vs_udr,
  input  logic               cmd_ready,
  input  logic               clear_overrun,
  output logic [DR_W-1:0]    jdo,
  output logic [IR_W-1:0]    jir,
  output logic [NUM_CMD-1:0] take_action,
  output logic [NUM_CMD-1:0] take_no_action,
  output logic               cmd_valid,
  output logic [LVL_W-1:0]   q_level,
  output logic               overrun
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = IR_W + DR_W;

  logic               w_uir_edge;
  logic               w_udr_edge;
  logic               w_full;
  logic               w_pop;
  logic               w_accept;
  logic               w_drop;
  logic [ENT_W-1:0]   w_head;
  logic [IR_W-1:0]    w_head_ir;
  logic [DR_W-1:0]    w_head_sr;

  logic [IR_W-1:0]    r_cur_ir;
  logic [ENT_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic [DR_W-1:0]    r_jdo;
  logic [IR_W-1:0]    r_jir;
  logic [NUM_CMD-1:0] r_take_action;
  logic [NUM_CMD-1:0] r_take_no_action;
  logic               r_overrun;

  nios_interrupt_jtag_debug_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (vs_uir),
    .o_edge  (w_uir_edge)
  );

  nios_interrupt_jtag_debug_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (vs_udr),
    .o_edge  (w_udr_edge)
  );

  assign w_head    = r_mem[r_rd_ptr];
  assign w_head_ir = w_head[ENT_W-1:DR_W];
  assign w_head_sr = w_head[DR_W-1:0];

  assign cmd_valid = (r_level != '0);
  assign w_full    = (r_level == LVL_W'(DEPTH));
  assign w_pop     = cmd_valid & cmd_ready;
  // A pop frees the head slot in the same cycle, so a full queue still
  // accepts a coincident push.
  assign w_accept  = w_udr_edge & (~w_full | w_pop);
  assign w_drop    = w_udr_edge & w_full & ~w_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cur_ir         <= '0;
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_level          <= '0;
      r_jdo            <= '0;
      r_jir            <= '0;
      r_take_action    <= '0;
      r_take_no_action <= '0;
      r_overrun        <= 1'b0;
    end else begin
      if (w_uir_edge) r_cur_ir <= ir_in;
      if (w_accept)   r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)      r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_level <= r_level + LVL_W'(w_accept) - LVL_W'(w_pop);

      if (w_drop)             r_overrun <= 1'b1;
      else if (clear_overrun) r_overrun <= 1'b0;

      r_take_action    <= '0;
      r_take_no_action <= '0;
      if (w_pop) begin
        r_jdo <= w_head_sr;
        r_jir <= w_head_ir;
        if (w_head_sr[ACT_BIT]) r_take_action[w_head_ir]    <= 1'b1;
        else                    r_take_no_action[w_head_ir] <= 1'b1;
      end
    end
  end

  // NOTE: the entry storage has no reset; q_level and the pointers decide
  // which slots are meaningful, so clearing the data itself buys nothing.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= {r_cur_ir, sr};
  end

  assign jdo            = r_jdo;
  assign jir            = r_jir;
  assign take_action    = r_take_action;
  assign take_no_action = r_take_no_action;
  assign q_level        = r_level;
  assign overrun        = r_overrun;

endmodule

// File: tb/tb_nios_interrupt_jtag_debug_cmd_queue.sv
// Bench for the debug command queue: a queue-based model checked every cycle
// against the default instance, directed scenarios, and a wide/deep instance.
module tb_nios_interrupt_jtag_debug_cmd_queue;
  import nios_interrupt_jtag_debug_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  ir_in = '0;
  logic [37:0] sr = '0;
  logic        vs_uir = 1'b0, vs_udr = 1'b0, cmd_ready = 1'b0, clear_overrun = 1'b0;
  logic [37:0] jdo;
  logic [1:0]  jir;
  logic [3:0]  take_action, take_no_action;
  logic        cmd_valid, overrun;
  logic [2:0]  q_level;

  logic [2:0]  b_ir_in = '0;
  logic [15:0] b_sr = '0;
  logic        b_vs_uir = 1'b0, b_vs_udr = 1'b0, b_cmd_ready = 1'b0, b_clear = 1'b0;
  logic [15:0] b_jdo;
  logic [2:0]  b_jir;
  logic [7:0]  b_ta, b_tna;
  logic        b_cmd_valid, b_overrun;
  logic [3:0]  b_q_level;

  nios_interrupt_jtag_debug_cmd_queue dut (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr), .vs_uir(vs_uir),
    .vs_udr(vs_udr), .cmd_ready(cmd_ready), .clear_overrun(clear_overrun),
    .jdo(jdo), .jir(jir), .take_action(take_action), .take_no_action(take_no_action),
    .cmd_valid(cmd_valid), .q_level(q_level), .overrun(overrun)
  );

  nios_interrupt_jtag_debug_cmd_queue #(.IR_W(3), .DR_W(16), .DEPTH(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .ir_in(b_ir_in), .sr(b_sr), .vs_uir(b_vs_uir),
    .vs_udr(b_vs_udr), .cmd_ready(b_cmd_ready), .clear_overrun(b_clear),
    .jdo(b_jdo), .jir(b_jir), .take_action(b_ta), .take_no_action(b_tna),
    .cmd_valid(b_cmd_valid), .q_level(b_q_level), .overrun(b_overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a push lands two clocks after the first clock edge that sees the
  // rising update level; everything else is plain queue bookkeeping.
  int          cyc = 0;
  int          udr_sched[$];
  int          uir_sched[$];
  logic [39:0] mq[$];
  logic [37:0] m_jdo;
  logic [1:0]  m_jir, m_cur_ir;
  logic [3:0]  m_ta, m_tna;
  logic        m_ovr;
  bit          chk_en = 1'b0;
  bit          rnd_done = 1'b0;

  task automatic model_clear();
    mq.delete(); udr_sched.delete(); uir_sched.delete();
    m_jdo = '0; m_jir = '0; m_cur_ir = '0; m_ta = '0; m_tna = '0; m_ovr = 1'b0;
  endtask

  task automatic model_step();
    bit push, upd, pop;
    logic [39:0] e;
    push = (udr_sched.size() != 0) && (udr_sched[0] == cyc);
    upd  = (uir_sched.size() != 0) && (uir_sched[0] == cyc);
    if (push) void'(udr_sched.pop_front());
    if (upd)  void'(uir_sched.pop_front());
    pop = (mq.size() != 0) && cmd_ready;
    m_ta = '0; m_tna = '0;
    if (pop) begin
      e = mq.pop_front();
      m_jir = e[39:38];
      m_jdo = e[37:0];
      if (m_jdo[37]) m_ta[m_jir] = 1'b1;
      else           m_tna[m_jir] = 1'b1;
    end
    if (clear_overrun) m_ovr = 1'b0;
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back({m_cur_ir, sr});
      else                   m_ovr = 1'b1;
    end
    if (upd) m_cur_ir = ir_in;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset_n) model_step();
    else         model_clear();
  end

  initial forever begin
    @(negedge reset_n);
    model_clear();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("cmd_valid", 64'(cmd_valid), 64'(mq.size() != 0));
      check("q_level", 64'(q_level), 64'(mq.size()));
      check("overrun", 64'(overrun), 64'(m_ovr));
      check("jdo", 64'(jdo), 64'(m_jdo));
      check("jir", 64'(jir), 64'(m_jir));
      check("take_action", 64'(take_action), 64'(m_ta));
      check("take_no_action", 64'(take_no_action), 64'(m_tna));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic udr_pulse(input logic [37:0] v, input int hi, input int lo);
    @(negedge clk);
    sr = v; vs_udr = 1'b1;
    udr_sched.push_back(cyc + 3);
    repeat (hi) @(negedge clk);
    vs_udr = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic uir_pulse(input logic [1:0] v, input int hi, input int lo);
    @(negedge clk);
    ir_in = v; vs_uir = 1'b1;
    uir_sched.push_back(cyc + 3);
    repeat (hi) @(negedge clk);
    vs_uir = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((udr_sched.size() != 0 || uir_sched.size() != 0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("sched_drain", 64'(udr_sched.size() + uir_sched.size()), 64'(0));
  endtask

  task automatic wait_any_pulse();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (take_action == '0 && take_no_action == '0 && n < 12);
    check("pulse_seen", 64'(|(take_action | take_no_action)), 64'(1));
  endtask

  logic [18:0] bq[$];

  task automatic b_cmd(input logic [2:0] ir, input logic [15:0] d, input bit accept);
    @(negedge clk);
    b_ir_in = ir; b_vs_uir = 1'b1;
    @(negedge clk);
    b_sr = d; b_vs_udr = 1'b1;
    @(negedge clk);
    b_vs_uir = 1'b0; b_vs_udr = 1'b0;
    repeat (2) @(negedge clk);
    if (accept) bq.push_back({ir, d});
  endtask

  task automatic b_drain(input int n);
    logic [18:0] e;
    logic [7:0]  onehot;
    @(negedge clk);
    b_cmd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      e = bq.pop_front();
      onehot = 8'd1 << e[18:16];
      check("b_jdo", 64'(b_jdo), 64'(e[15:0]));
      check("b_jir", 64'(b_jir), 64'(e[18:16]));
      check("b_take_action", 64'(b_ta), 64'(e[15] ? onehot : 8'd0));
      check("b_take_no_action", 64'(b_tna), 64'(e[15] ? 8'd0 : onehot));
    end
    @(negedge clk);
    b_cmd_ready = 1'b0;
  endtask

  logic [37:0] v3 [5];
  logic [37:0] v4 [5];
  int          c0;

  initial begin
    v3 = '{38'h20_0000_00A0, 38'h00_0000_00A1, 38'h20_0000_00A2, 38'h00_0000_00A3, 38'h20_0000_00A4};
    v4 = '{38'h00_0000_0B00, 38'h20_0000_0B01, 38'h00_0000_0B02, 38'h20_0000_0B03, 38'h20_0000_0B04};

    repeat (3) @(negedge clk);
    check("rst_q_level", 64'(q_level), 64'(0));
    check("rst_cmd_valid", 64'(cmd_valid), 64'(0));
    check("rst_pulses", 64'({take_action, take_no_action}), 64'(0));
    check("rst_jdo_jir", 64'({jdo, jir}), 64'(0));
    check("rst_overrun", 64'(overrun), 64'(0));
    check("b_rst_level", 64'(b_q_level), 64'(0));
    reset_n = 1'b1;
    chk_en  = 1'b1;
    repeat (6) @(negedge clk);

    // Single BREAK command with action bit set.
    uir_pulse(2'(BREAK), 1, 1);
    wait_idle();
    cmd_ready = 1'b1;
    @(negedge clk);
    sr = 38'h20_0000_0055; vs_udr = 1'b1;
    udr_sched.push_back(cyc + 3);
    @(posedge clk); @(posedge clk); #1;
    check("lat_before_edge3", 64'(cmd_valid), 64'(0));
    @(posedge clk); #1;
    check("lat_valid_edge3", 64'(cmd_valid), 64'(1));
    @(negedge clk);
    vs_udr = 1'b0;
    @(posedge clk); #1;
    check("t1_take_action", 64'(take_action), 64'(4'b0100));
    check("t1_take_no_action", 64'(take_no_action), 64'(0));
    check("t1_jdo", 64'(jdo), 64'(38'h20_0000_0055));
    check("t1_jir", 64'(jir), 64'(2));
    @(posedge clk); #1;
    check("t1_pulse_single", 64'(take_action), 64'(0));

    // No-action command on TRACEMEM.
    uir_pulse(2'(TRACEMEM), 1, 1);
    udr_pulse(38'h00_1234_5678, 1, 1);
    wait_any_pulse();
    check("t2_take_no_action", 64'(take_no_action), 64'(4'b0010));
    check("t2_take_action", 64'(take_action), 64'(0));
    check("t2_jdo", 64'(jdo), 64'(38'h00_1234_5678));
    @(posedge clk); #1;
    check("t2_pulse_single", 64'(take_no_action), 64'(0));

    // Five pushes into a four-deep queue, then clear and drain in order.
    @(negedge clk);
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) udr_pulse(v3[i], 1, 1);
    wait_idle();
    check("t3_level_full", 64'(q_level), 64'(4));
    check("t3_overrun_set", 64'(overrun), 64'(1));
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    check("t3_overrun_clr", 64'(overrun), 64'(0));
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("t3_fifo_jdo", 64'(jdo), 64'(v3[i]));
      check("t3_one_pulse", 64'($countones({take_action, take_no_action})), 64'(1));
    end
    @(posedge clk); #1;
    check("t3_drained", 64'({q_level, take_action, take_no_action}), 64'(0));

    // Full queue with a push landing on the same edge as a pop.
    @(negedge clk);
    cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) udr_pulse(v4[i], 1, 1);
    wait_idle();
    check("t4_level_full", 64'(q_level), 64'(4));
    @(negedge clk);
    sr = v4[4]; vs_udr = 1'b1;
    c0 = cyc;
    udr_sched.push_back(c0 + 3);
    @(negedge clk);
    @(negedge clk);
    cmd_ready = 1'b1; vs_udr = 1'b0;
    @(posedge clk); #1;
    check("t4_level_kept", 64'(q_level), 64'(4));
    check("t4_no_overrun", 64'(overrun), 64'(0));
    check("t4_first_pop", 64'(jdo), 64'(v4[0]));
    for (int i = 1; i < 5; i++) begin
      @(posedge clk); #1;
      check("t4_order", 64'(jdo), 64'(v4[i]));
    end
    check("t4_empty", 64'(q_level), 64'(0));

    // Reset with entries queued, with vs_udr held high across release.
    @(negedge clk);
    cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) udr_pulse(v3[i], 1, 1);
    wait_idle();
    check("t5_level3", 64'(q_level), 64'(3));
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    vs_udr  = 1'b1;
    #1;
    check("t5_async_level", 64'(q_level), 64'(0));
    check("t5_async_valid", 64'(cmd_valid), 64'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("t5_held_no_push", 64'({q_level, cmd_valid}), 64'(0));
    vs_udr = 1'b0;
    repeat (3) @(negedge clk);
    udr_pulse(38'h20_0000_0C0C, 1, 1);
    wait_idle();
    check("t5_push_after_low", 64'(q_level), 64'(1));
    cmd_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Randomized traffic, checked every cycle against the model.
    fork
      begin
        fork
          for (int i = 0; i < 150; i++)
            udr_pulse(38'({$urandom(), $urandom()}), $urandom_range(1, 3), $urandom_range(1, 4));
          for (int i = 0; i < 60; i++)
            uir_pulse(2'($urandom()), $urandom_range(1, 3), $urandom_range(2, 8));
        join
        rnd_done = 1'b1;
      end
      while (!rnd_done) begin
        @(negedge clk);
        cmd_ready     = ($urandom_range(0, 9) < (((cyc / 150) % 2) != 0 ? 3 : 8));
        clear_overrun = ($urandom_range(0, 15) == 0);
      end
    join
    cmd_ready = 1'b1; clear_overrun = 1'b0;
    wait_idle();
    repeat (8) @(negedge clk);
    check("rnd_drained", 64'(q_level), 64'(0));

    // Wide/deep instance: eight entries accepted, ninth dropped, wrap.
    for (int i = 0; i < 9; i++) b_cmd(3'(i), 16'($urandom()), i < 8);
    check("b_level8", 64'(b_q_level), 64'(8));
    check("b_overrun", 64'(b_overrun), 64'(1));
    check("b_valid", 64'(b_cmd_valid), 64'(1));
    b_drain(8);
    check("b_empty", 64'(b_q_level), 64'(0));
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 5; k++) b_cmd(3'($urandom()), 16'($urandom()), 1'b1);
      check("b_level5", 64'(b_q_level), 64'(5));
      b_drain(5);
    end
    check("b_overrun_sticky", 64'(b_overrun), 64'(1));
    b_clear = 1'b1;
    @(negedge clk);
    b_clear = 1'b0;
    check("b_overrun_clr", 64'(b_overrun), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
